pipe_barrel_shifter: RTL

//   Parametrised, fully pipelined barrel shifter for the NPC execute path. Supports

---
 rtl/pipe_barrel_shifter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA/ROR, one log2 level per registered stage.
// Ports: clk, rst (async high); in_valid/in_ready/in_din/in_shamt/in_op/in_tag;
//        out_valid/out_ready/out_dout/out_tag/out_carry.
// Optional: define BSHIFT_CARRY_EN to track the last bit shifted out (out_carry).
module pipe_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_din,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_dout,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_carry
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // stage registers
    logic [SHW-1:0]   vld;
    logic [WIDTH-1:0] val  [SHW];
    logic [1:0]       opq  [SHW];
    logic [SHW-1:0]   shq  [SHW];
    logic [TAG_W-1:0] tagq [SHW];

    // per-stage inputs (stage 0 from ports, stage k from stage k-1)
    logic [SHW-1:0]   sv;
    logic [WIDTH-1:0] sd [SHW];
    logic [1:0]       so [SHW];
    logic [SHW-1:0]   ss [SHW];
    logic [TAG_W-1:0] st [SHW];

    logic [WIDTH-1:0] nd [SHW];
    logic [SHW-1:0]   ld;

    // Stage k loads when any stage from k to the end is empty or the sink
    // accepts; this is the unrolled form of ld[k] = ~vld[k] | ld[k+1].
    for (genvar k = 0; k < SHW; k++) begin : g_ld
        assign ld[k] = out_ready | ~(&vld[SHW-1:k]);
    end

    assign in_ready = ld[0] & ~rst;

    always_comb begin
        sv[0] = in_valid;
        sd[0] = in_din;
        so[0] = in_op;
        ss[0] = in_shamt;
        st[0] = in_tag;
        for (int k = 1; k < SHW; k++) begin
            sv[k] = vld[k-1];
            sd[k] = val[k-1];
            so[k] = opq[k-1];
            ss[k] = shq[k-1];
            st[k] = tagq[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            nd[k] = sd[k];
            if (ss[k][k]) begin
                unique case (so[k])
                    OP_SLL: nd[k] = sd[k] << (1 << k);
                    OP_SRL: nd[k] = sd[k] >> (1 << k);
                    // sign bit never moves under SRA, so the stage MSB is din's MSB
                    OP_SRA: nd[k] = $signed(sd[k]) >>> (1 << k);
                    OP_ROR: nd[k] = (sd[k] >> (1 << k))
                                  | (sd[k] << (WIDTH - (1 << k)));
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int k = 0; k < SHW; k++) begin
                val[k]  <= '0;
                opq[k]  <= '0;
                shq[k]  <= '0;
                tagq[k] <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (ld[k]) begin
                    vld[k] <= sv[k];
                    if (sv[k]) begin
                        val[k]  <= nd[k];
                        opq[k]  <= so[k];
                        shq[k]  <= ss[k];
                        tagq[k] <= st[k];
                    end
                end
            end
        end
    end

    assign out_valid = vld[SHW-1];
    assign out_dout  = val[SHW-1];
    assign out_tag   = tagq[SHW-1];

`ifdef BSHIFT_CARRY_EN
    logic             cyq [SHW];
    logic             sc  [SHW];
    logic             nc  [SHW];
    logic [WIDTH-1:0] t;

    always_comb begin
        sc[0] = 1'b0;
        for (int k = 1; k < SHW; k++) begin
            sc[k] = cyq[k-1];
        end
    end

    // Last bit pushed out at this level. ROR's new MSB is v[2^k-1],
    // the same bit SRL/SRA drop last.
    always_comb begin
        t = '0;
        for (int k = 0; k < SHW; k++) begin
            nc[k] = sc[k];
            t = '0;
            if (ss[k][k]) begin
                if (so[k] == OP_SLL) begin
                    t = sd[k] >> (WIDTH - (1 << k));
                end else begin
                    t = sd[k] >> ((1 << k) - 1);
                end
                nc[k] = t[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                cyq[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (ld[k] && sv[k]) begin
                    cyq[k] <= nc[k];
                end
            end
        end
    end

    assign out_carry = cyq[SHW-1];
`else
    assign out_carry = 1'b0;
`endif

endmodule
